// File: rtl/fact_seq_pkg.sv
// fact_seq_pkg: sequencer states, factorial-core register offsets and command values
package fact_seq_pkg;
  typedef enum logic [3:0] {
    IDLE, W_OPND, W_IEN, W_START, WAIT_INT, R_LO, R_LO_CAP, R_HI, R_HI_CAP, W_CLR1, W_CLR0, DONE
  } state_t;
  localparam logic [15:0] OFS_OPSTART  = 16'h00;
  localparam logic [15:0] OFS_OPCLEAR  = 16'h08;
  localparam logic [15:0] OFS_INTREN   = 16'h18;
  localparam logic [15:0] OFS_OPERAND  = 16'h20;
  localparam logic [15:0] OFS_RESULT_H = 16'h28;
  localparam logic [15:0] OFS_RESULT_L = 16'h30;
  localparam logic [63:0] OPSTART_GO   = 64'd1;
  localparam logic [63:0] INTREN_ON    = 64'd1;
  localparam logic [63:0] OPCLEAR_SET  = 64'd1;
  localparam logic [63:0] OPCLEAR_REL  = 64'd0;
endpackage

// File: rtl/fact_seq_timeout.sv
// fact_seq_timeout: loadable down-counter with an expired flag
// Ports: clk/reset_n clocking; load/load_val preset the count; en decrements; expired = count is zero.
module fact_seq_timeout #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (load) count <= load_val;
    else if (en && count != '0) count <= count - 1'b1;
  assign expired = count == '0;
endmodule

// File: rtl/fact_job_sequencer.sv
// fact_job_sequencer: bus master that runs factorial jobs on the memory-mapped factorial core
// Ports: job_valid/job_operand/job_ready job intake; m_req/m_grant/m_wr/m_addr/m_dout/m_din bus master;
//        interrupt core done level; res_valid/res_h/res_l/res_err result; busy = not idle.
module fact_job_sequencer
  import fact_seq_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR      = 16'h7000,
  parameter int          TIMEOUT_CYCLES = 8192
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        job_valid,
  input  logic [63:0] job_operand,
  output logic        job_ready,
  output logic        m_req,
  input  logic        m_grant,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [63:0] m_dout,
  input  logic [63:0] m_din,
  input  logic        interrupt,
  output logic        res_valid,
  output logic [63:0] res_h,
  output logic [63:0] res_l,
  output logic        res_err,
  output logic        busy
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) > 0 ? $clog2(TIMEOUT_CYCLES) : 1;
  state_t state, state_n;
  logic [63:0] operand;
  logic [15:0] ofs;
  logic err, expired;
  // the counter is preset outside WAIT_INT so every wait starts from a full budget
  fact_seq_timeout #(.W(CW)) u_timeout (
    .clk(clk),
    .reset_n(reset_n),
    .load(state != WAIT_INT),
    .load_val(CW'(TIMEOUT_CYCLES - 1)),
    .en(state == WAIT_INT),
    .expired(expired)
  );
  always_comb begin
    state_n = state;
    m_req = 1'b0;
    m_wr = 1'b0;
    ofs = '0;
    m_dout = '0;
    case (state)
      IDLE: state_n = job_valid ? W_OPND : IDLE;
      W_OPND: begin
        {m_req, m_wr, ofs, m_dout} = {2'b11, OFS_OPERAND, operand};
        state_n = m_grant ? W_IEN : state;
      end
      W_IEN: begin
        {m_req, m_wr, ofs, m_dout} = {2'b11, OFS_INTREN, INTREN_ON};
        state_n = m_grant ? W_START : state;
      end
      W_START: begin
        {m_req, m_wr, ofs, m_dout} = {2'b11, OFS_OPSTART, OPSTART_GO};
        state_n = m_grant ? WAIT_INT : state;
      end
      WAIT_INT: state_n = interrupt ? R_LO : expired ? W_CLR1 : WAIT_INT;
      R_LO: begin
        {m_req, ofs} = {1'b1, OFS_RESULT_L};
        state_n = m_grant ? R_LO_CAP : state;
      end
      R_LO_CAP: begin
        {m_req, ofs} = {1'b1, OFS_RESULT_L};
        state_n = m_grant ? R_HI : state;
      end
      R_HI: begin
        {m_req, ofs} = {1'b1, OFS_RESULT_H};
        state_n = m_grant ? R_HI_CAP : state;
      end
      R_HI_CAP: begin
        {m_req, ofs} = {1'b1, OFS_RESULT_H};
        state_n = m_grant ? W_CLR1 : state;
      end
      W_CLR1: begin
        {m_req, m_wr, ofs, m_dout} = {2'b11, OFS_OPCLEAR, OPCLEAR_SET};
        state_n = m_grant ? W_CLR0 : state;
      end
      W_CLR0: begin
        {m_req, m_wr, ofs, m_dout} = {2'b11, OFS_OPCLEAR, OPCLEAR_REL};
        state_n = m_grant ? DONE : state;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign m_addr = m_req ? BASE_ADDR + ofs : 16'h0;
  assign job_ready = state == IDLE;
  assign busy = !job_ready;
  assign res_valid = state == DONE;
  assign res_err = res_valid && err;
  // read data is taken in the capture cycle, and only on a granted edge so a stalled capture retakes it
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      operand <= '0;
      err <= 1'b0;
      res_l <= '0;
      res_h <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && job_valid) {operand, err} <= {job_operand, 1'b0};
      if (state == WAIT_INT && !interrupt && expired) err <= 1'b1;
      if (state == R_LO_CAP && m_grant) res_l <= m_din;
      if (state == R_HI_CAP && m_grant) res_h <= m_din;
    end
endmodule

// File: tb/tb_fact_job_sequencer.sv
// tb_fact_job_sequencer: directed self-checking bench with a behavioural factorial-core model
module tb_fact_job_sequencer;
  logic clk, reset_n, job_valid, job_ready, m_req, m_grant, m_wr, res_valid, res_err, busy;
  logic [63:0] job_operand, m_dout, m_din, res_h, res_l;
  logic [15:0] m_addr;
  logic interrupt = 1'b0;
  int icnt = -1;
  int int_delay;
  logic [63:0] core_op = '0;
  logic [127:0] core_res = '0;
  bit rand_g = 1'b0;
  int checks = 0, errors = 0, ib_cnt = 0, rv_cnt = 0, tot_rv = 0, n;
  logic lat_err;
  logic [15:0] log_addr[$];
  logic log_wr[$];
  logic [63:0] log_dat[$];
  logic [15:0] t_addr[9] = '{16'h7020, 16'h7018, 16'h7000, 16'h7030, 16'h7030, 16'h7028, 16'h7028, 16'h7008, 16'h7008};
  logic t_wr[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [63:0] t_dat[9] = '{64'd0, 64'd1, 64'd1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd1, 64'd0};

  fact_job_sequencer #(.BASE_ADDR(16'h7000), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .job_valid(job_valid), .job_operand(job_operand),
    .job_ready(job_ready), .m_req(m_req), .m_grant(m_grant), .m_wr(m_wr), .m_addr(m_addr),
    .m_dout(m_dout), .m_din(m_din), .interrupt(interrupt), .res_valid(res_valid),
    .res_h(res_h), .res_l(res_l), .res_err(res_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    m_grant = 1'b1;
    forever begin
      @(negedge clk);
      m_grant = rand_g ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic logic [127:0] fact(input logic [63:0] v);
    logic [127:0] r = 128'd1;
    for (longint i = 2; i <= longint'(v); i++) r = r * 128'(i);
    return r;
  endfunction

  assign m_din = m_addr == 16'h7030 ? core_res[63:0] : m_addr == 16'h7028 ? core_res[127:64] : 64'h0;

  always @(posedge clk) begin
    if (m_req && m_grant && m_wr && m_addr == 16'h7020) core_op <= m_dout;
    if (m_req && m_grant && m_wr && m_addr == 16'h7000 && m_dout == 64'd1) begin
      core_res <= fact(core_op);
      icnt <= int_delay;
      interrupt <= int_delay == 0;
    end else if (m_req && m_grant && m_wr && m_addr == 16'h7008 && m_dout == 64'd1) begin
      icnt <= -1;
      interrupt <= 1'b0;
    end else if (icnt > 0) begin
      icnt <= icnt - 1;
      if (icnt == 1) interrupt <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (m_req && m_grant) begin
      log_addr.push_back(m_addr);
      log_wr.push_back(m_wr);
      log_dat.push_back(m_dout);
    end
    if (busy && !m_req) ib_cnt++;
    if (res_valid) begin
      rv_cnt++;
      tot_rv++;
      lat_err = res_err;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_job(input logic [63:0] op, input int dly);
    int_delay = dly;
    log_addr.delete();
    log_wr.delete();
    log_dat.delete();
    ib_cnt = 0;
    rv_cnt = 0;
    chk("job_ready_idle", job_ready, 1);
    job_valid = 1'b1;
    job_operand = op;
    @(negedge clk);
    chk("accept_ready_low", job_ready, 0);
    chk("accept_busy", busy, 1);
    chk("first_req", m_req, 1);
    chk("first_addr", m_addr, 16'h7020);
    job_operand = 64'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic finish_job(input logic [63:0] op, input logic [63:0] eh, input logic [63:0] el,
                            input logic ee, input bit full, input int wcyc);
    int w = 0;
    int en;
    int k;
    while (rv_cnt == 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("res_valid_pulse", rv_cnt, 1);
    chk("res_err", lat_err, ee);
    if (full) begin
      chk("res_h", res_h, eh);
      chk("res_l", res_l, el);
    end
    chk("job_ready_after_done", job_ready, 1);
    chk("wait_int_cycles", ib_cnt, wcyc + 1);
    en = full ? 9 : 5;
    chk("commit_count", log_addr.size(), en);
    for (int i = 0; i < en && i < log_addr.size(); i++) begin
      k = (full || i < 3) ? i : i + 4;
      chk($sformatf("commit%0d_addr", i), log_addr[i], t_addr[k]);
      chk($sformatf("commit%0d_wr", i), log_wr[i], t_wr[k]);
      if (t_wr[k]) chk($sformatf("commit%0d_data", i), log_dat[i], k == 0 ? op : t_dat[k]);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    job_valid = 1'b0;
    job_operand = '0;
    int_delay = 2;
    repeat (2) @(negedge clk);
    chk("rst_job_ready", job_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_m_req", m_req, 0);
    chk("rst_m_wr", m_wr, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_dout", m_dout, 0);
    chk("rst_res_h", res_h, 0);
    chk("rst_res_l", res_l, 0);
    reset_n = 1'b1;
    @(negedge clk);
    start_job(64'd10, 2);
    finish_job(64'd10, 64'h0, 64'h375F00, 1'b0, 1'b1, 3);
    start_job(64'd25, 5);
    finish_job(64'd25, 64'hCD4A0, 64'h619FB0907BC00000, 1'b0, 1'b1, 6);
    start_job(64'd0, 0);
    finish_job(64'd0, 64'h0, 64'h1, 1'b0, 1'b1, 1);
    start_job(64'd1, 0);
    finish_job(64'd1, 64'h0, 64'h1, 1'b0, 1'b1, 1);
    start_job(64'd10, 15);
    finish_job(64'd10, 64'h0, 64'h375F00, 1'b0, 1'b1, 16);
    rand_g = 1'b1;
    start_job(64'd10, 4);
    finish_job(64'd10, 64'h0, 64'h375F00, 1'b0, 1'b1, 5);
    start_job(64'd25, 3);
    finish_job(64'd25, 64'hCD4A0, 64'h619FB0907BC00000, 1'b0, 1'b1, 4);
    rand_g = 1'b0;
    start_job(64'd7, -1);
    finish_job(64'd7, 64'h0, 64'h0, 1'b1, 1'b0, 16);
    start_job(64'd25, 3);
    n = 0;
    while (m_addr !== 16'h7028 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_r_hi", m_addr, 16'h7028);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_m_req", m_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_job_ready", job_ready, 1);
    chk("mid_rst_m_addr", m_addr, 0);
    chk("mid_rst_res_l", res_l, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start_job(64'd10, 2);
    finish_job(64'd10, 64'h0, 64'h375F00, 1'b0, 1'b1, 3);
    chk("total_res_valid", tot_rv, 9);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fact_job_sequencer.md
# fact_job_sequencer

Bus-master controller that runs factorial jobs on the memory-mapped factorial core at BASE_ADDR without CPU involvement. It accepts operands through a valid/ready job port and requests the shared bus. For each job it programs operand, intrEn and opstart, then releases the bus while the core computes. On interrupt it reads result_l and result_h, clears the core with opclear 1 then 0, and presents the 128-bit result. It sits beside the existing master on the Top bus and competes for m_grant.

## Interface
- BASE_ADDR, 16'h7000, core base. Register offsets: opstart +0x00, opclear +0x08, intrEn +0x18, operand +0x20, result_h +0x28, result_l +0x30.
- TIMEOUT_CYCLES, 8192, maximum cycles spent in WAIT_INT before an error abort.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- job_valid  in  1  operand offered.
- job_operand  in  64  factorial operand.
- job_ready  out  1  high only in IDLE.
- m_req  out  1  bus request.
- m_grant  in  1  bus granted this cycle.
- m_wr  out  1  1 = write, 0 = read.
- m_addr  out  16  bus address.
- m_dout  out  64  write data.
- m_din  in  64  read data.
- interrupt  in  1  core done, level; held high until opclear.
- res_valid  out  1  one-cycle pulse, result fields valid.
- res_h, res_l  out  64 each  result words, held until the next res_valid.
- res_err  out  1  qualifies res_valid; 1 = timeout abort.
- busy  out  1  1 in every state except IDLE.

## Operation
- States: IDLE, W_OPND, W_IEN, W_START, WAIT_INT, R_LO, R_LO_CAP, R_HI, R_HI_CAP, W_CLR1, W_CLR0, DONE.
- IDLE: accept a job when job_valid and job_ready are both high. Latch job_operand and go to W_OPND.
- Bus commit: a commit happens at a rising edge where m_req and m_grant are both high. Each bus state advances only on commit; without grant the state and outputs hold.
- Write states:
  - W_OPND: write the latched operand to +0x20.
  - W_IEN: write 1 to +0x18.
  - W_START: write 1 to +0x00.
  - W_CLR1: write 1 to +0x08.
  - W_CLR0: write 0 to +0x08.
- WAIT_INT: m_req is 0 and a cycle counter runs.
  - interrupt high: go to R_LO.
  - Counter reaches TIMEOUT_CYCLES-1: set the error flag and go to W_CLR1, skipping both reads.
- Reads:
  - R_LO: m_wr=0, m_addr=+0x30. After commit, go to R_LO_CAP.
  - R_LO_CAP: keep m_req and the address, capture m_din into res_l at the edge ending the cycle, go to R_HI.
  - R_HI / R_HI_CAP: same pattern for +0x28 into res_h.
- DONE: pulse res_valid for one cycle with res_err = error flag, then return to IDLE.
- m_req is held continuously across consecutive bus states within a phase: the three setup writes, and the reads followed by the clears.
- Arithmetic: m_addr = BASE_ADDR + offset, 16-bit with wrap. The sequencer never interprets result values.

## Timing
- Reset values: job_ready=1; busy, m_req, m_wr, res_valid, res_err = 0; m_addr, m_dout, res_h, res_l = 0. State = IDLE, counter and error flag = 0.
- Accept to first m_req: 1 cycle.
- Minimum setup with grant held: 3 cycles.
- Minimum readback with grant held: 4 read cycles + 2 clear cycles + 1 DONE cycle.
- Back-to-back jobs: job_ready returns the cycle after DONE.
- interrupt already high on entry to WAIT_INT (fast operands 0/1): R_LO on the next edge.
- Grant removed mid-phase: the current access stalls with no repeat or skip. A capture cycle without grant holds and recaptures once grant returns.
- reset_n asserted mid-job: all outputs return to reset values immediately and the job is dropped. The core's state is the system's responsibility.
- job_valid while busy: ignored, since job_ready is 0.

## Structure
- Package fact_seq_pkg holds the state enum, the register offset constants and the OPSTART/OPCLEAR data values.
- One sub-module, fact_seq_timeout: a loadable down-counter with an expired flag.
- Everything else stays in one FSM plus datapath registers.

## Test plan
- Operand 10, grant tied high: bus writes 0x7020=10, 0x7018=1, 0x7000=1. After interrupt: res_l=0x375F00, res_h=0, res_err=0, followed by writes 0x7008=1 then 0x7008=0.
- Operand 25: res_h=0xCD4A0, res_l=0x619FB0907BC00000, one res_valid pulse.
- Operands 0 then 1 back-to-back: both yield res_l=1 and res_h=0. job_ready is low between accepts. No m_req during WAIT_INT.
- Grant toggled randomly at 50%: every commit happens in the order above, no address is duplicated, and results match the grant-tied-high run.
- interrupt never asserted with TIMEOUT_CYCLES=16: after 16 WAIT_INT cycles, clear writes occur with no reads, then res_valid=1 with res_err=1.
- reset_n pulsed low during R_HI: m_req=0 and busy=0 immediately. After release a new job of operand 10 completes correctly.
